timer_bus_controller: RTL

- Read/write front end and command sequencer for the three-counter 8254 timer.
- Decodes CPU bus cycles (CS/RD/WR/A1:A0) into single-cycle strobes toward each counter's control logic and counting element:
  - control-word load
  - counter-latch command
  - read-back command
  - LSB/MSB count writes
- Tracks per-counter byte pointers and latch flags.
- Muxes status and output-latch bytes onto the read data bus.

---
 rtl/timer_bus_controller_pkg.sv | 29 ++
 rtl/timer_byte_pointer.sv | 71 +++++++
 rtl/timer_bus_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/timer_bus_controller_pkg.sv
// Shared constants and types for the 8254 bus front end and its per-counter byte pointers.
package timer_bus_controller_pkg;

  localparam logic [1:0] ADDR_CW     = 2'd3;

  localparam logic [1:0] RW_LATCH    = 2'b00;
  localparam logic [1:0] RW_LSB      = 2'b01;
  localparam logic [1:0] RW_MSB      = 2'b10;
  localparam logic [1:0] RW_WORD     = 2'b11;

  localparam logic [1:0] SC_READBACK = 2'b11;

  // Control-word field positions; read-back reuses D5/D4 as active-low count/status selects.
  localparam int CW_SC_LSB      = 6;
  localparam int CW_RW_LSB      = 4;
  localparam int RB_NCOUNT_BIT  = 5;
  localparam int RB_NSTATUS_BIT = 4;
  localparam int RB_SEL_LSB     = 1;

  typedef enum logic {
    PTR_LSB = 1'b0,
    PTR_MSB = 1'b1
  } byte_ptr_e;

  function automatic byte_ptr_e start_ptr(input logic [1:0] rw);
    return (rw == RW_MSB) ? PTR_MSB : PTR_LSB;
  endfunction

endpackage

// File: rtl/timer_byte_pointer.sv
// Per-counter access state: programmed RW mode, write/read byte pointers and latch flags.
module timer_byte_pointer
  import timer_bus_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cw_evt,
  input  logic [1:0] cw_rw,
  input  logic       latch_cmd,
  input  logic       status_cmd,
  input  logic       wr_evt,
  input  logic       rd_evt,
  output logic       rd_ptr,
  output logic       stat_latched,
  output logic       do_count_latch,
  output logic       do_status_latch,
  output logic       do_release,
  output logic       do_cnt_wr,
  output logic       do_msb
);

  logic [1:0] rw_q;
  byte_ptr_e  wr_q;
  byte_ptr_e  rd_q;
  logic       cl_q;
  logic       sl_q;
  logic       final_rd;

  assign rd_ptr       = rd_q;
  assign stat_latched = sl_q;

  // A read finishes the latched value on its only byte, or on the MSB in word mode.
  always_comb begin
    final_rd        = (rw_q == RW_LSB) || (rw_q == RW_MSB) ||
                      ((rw_q == RW_WORD) && (rd_q == PTR_MSB));
    do_count_latch  = latch_cmd && !cl_q;
    do_status_latch = status_cmd && !sl_q;
    do_cnt_wr       = wr_evt && (rw_q != RW_LATCH);
    do_msb          = (rw_q == RW_WORD) ? (wr_q == PTR_MSB) : (rw_q == RW_MSB);
    do_release      = cl_q && (cw_evt || (rd_evt && !sl_q && final_rd));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q <= RW_LATCH;
      wr_q <= PTR_LSB;
      rd_q <= PTR_LSB;
      cl_q <= 1'b0;
      sl_q <= 1'b0;
    end else if (cw_evt) begin
      rw_q <= cw_rw;
      wr_q <= start_ptr(cw_rw);
      rd_q <= start_ptr(cw_rw);
      cl_q <= 1'b0;
      sl_q <= 1'b0;
    end else begin
      if (do_count_latch) cl_q <= 1'b1;
      if (do_status_latch) sl_q <= 1'b1;
      if (do_cnt_wr && (rw_q == RW_WORD)) wr_q <= byte_ptr_e'(~wr_q);
      if (rd_evt) begin
        if (sl_q) begin
          sl_q <= 1'b0;
        end else begin
          if (rw_q == RW_WORD) rd_q <= byte_ptr_e'(~rd_q);
          if (final_rd) cl_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/timer_bus_controller.sv
// 8254 CPU bus front end: synchronizes the bus, detects read/write cycle ends and
// issues one-cycle command strobes to the three counters; muxes read data back.
module timer_bus_controller
  import timer_bus_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CNT     = 3
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [1:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [2:0]  cw_load,
  output logic [7:0]  cw_data,
  output logic [2:0]  count_latch,
  output logic [2:0]  status_latch,
  output logic [2:0]  ol_release,
  output logic [2:0]  cnt_wr,
  output logic        cnt_wr_msb,
  output logic [7:0]  cnt_wr_data,
  input  logic [47:0] ol_in,
  input  logic [23:0] status_in
);

  localparam int          BW       = 13;
  localparam logic [12:0] BUS_IDLE = 13'h1C00;

  logic [BW-1:0] bus_raw;
  logic [BW-1:0] bus_s;

  assign bus_raw = {cs_n, rd_n, wr_n, addr, data_in};

  if (SYNC_STAGES == 0) begin : g_bypass
    assign bus_s = bus_raw;
  end else begin : g_sync
    logic [BW-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= BUS_IDLE;
      end else begin
        sync_q[0] <= bus_raw;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign bus_s = sync_q[SYNC_STAGES-1];
  end

  logic       s_cs_n, s_rd_n, s_wr_n;
  logic [1:0] s_addr;
  logic [7:0] s_data;
  logic       p_cs_n, p_rd_n, p_wr_n;
  logic [1:0] p_addr;
  logic [7:0] p_data;

  assign {s_cs_n, s_rd_n, s_wr_n, s_addr, s_data} = bus_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cs_n <= 1'b1;
      p_rd_n <= 1'b1;
      p_wr_n <= 1'b1;
      p_addr <= 2'd0;
      p_data <= 8'h00;
    end else begin
      p_cs_n <= s_cs_n;
      p_rd_n <= s_rd_n;
      p_wr_n <= s_wr_n;
      p_addr <= s_addr;
      p_data <= s_data;
    end
  end

  // Bus event semantics: a cycle completes on the synchronized rising edge of rd_n or wr_n
  // while cs_n was low at the previous sample; address and data are taken from that previous
  // sample (the values held during the strobe). A previous sample with rd_n and wr_n both
  // low is a bus conflict and produces no event. Each event yields exactly one cycle of
  // strobes, registered in the cycle after detection.
  logic wr_evt, rd_evt, is_cw;
  logic [1:0] cw_sc, cw_rw;

  assign wr_evt = !p_cs_n && !p_wr_n && p_rd_n && s_wr_n;
  assign rd_evt = !p_cs_n && !p_rd_n && p_wr_n && s_rd_n;
  assign is_cw  = wr_evt && (p_addr == ADDR_CW);
  assign cw_sc  = p_data[CW_SC_LSB +: 2];
  assign cw_rw  = p_data[CW_RW_LSB +: 2];

  logic [NUM_CNT-1:0] cw_evt, latch_cmd, status_cmd, wr_cnt_evt, rd_cnt_evt;
  logic [NUM_CNT-1:0] rd_ptr, stat_latched;
  logic [NUM_CNT-1:0] do_cl, do_sl, do_rel, do_wr, do_msb;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    localparam logic [1:0] IDX = 2'(i);
    logic rb_sel;

    assign rb_sel        = is_cw && (cw_sc == SC_READBACK) && p_data[RB_SEL_LSB + i];
    assign cw_evt[i]     = is_cw && (cw_sc == IDX) && (cw_rw != RW_LATCH);
    assign latch_cmd[i]  = (is_cw && (cw_sc == IDX) && (cw_rw == RW_LATCH)) ||
                           (rb_sel && !p_data[RB_NCOUNT_BIT]);
    assign status_cmd[i] = rb_sel && !p_data[RB_NSTATUS_BIT];
    assign wr_cnt_evt[i] = wr_evt && (p_addr == IDX);
    assign rd_cnt_evt[i] = rd_evt && (p_addr == IDX);

    timer_byte_pointer u_ptr (
      .clk             (clk),
      .rst_n           (rst_n),
      .cw_evt          (cw_evt[i]),
      .cw_rw           (cw_rw),
      .latch_cmd       (latch_cmd[i]),
      .status_cmd      (status_cmd[i]),
      .wr_evt          (wr_cnt_evt[i]),
      .rd_evt          (rd_cnt_evt[i]),
      .rd_ptr          (rd_ptr[i]),
      .stat_latched    (stat_latched[i]),
      .do_count_latch  (do_cl[i]),
      .do_status_latch (do_sl[i]),
      .do_release      (do_rel[i]),
      .do_cnt_wr       (do_wr[i]),
      .do_msb          (do_msb[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_load      <= '0;
      cw_data      <= 8'h00;
      count_latch  <= '0;
      status_latch <= '0;
      ol_release   <= '0;
      cnt_wr       <= '0;
      cnt_wr_msb   <= 1'b0;
      cnt_wr_data  <= 8'h00;
    end else begin
      cw_load      <= cw_evt;
      count_latch  <= do_cl;
      status_latch <= do_sl;
      ol_release   <= do_rel;
      cnt_wr       <= do_wr;
      if (|cw_evt) cw_data <= p_data;
      if (|do_wr) begin
        cnt_wr_msb  <= |(do_wr & do_msb);
        cnt_wr_data <= p_data;
      end
    end
  end

  // Read data follows the synchronized bus combinationally; a latched status byte wins.
  logic rd_active;
  assign rd_active = !s_cs_n && !s_rd_n && s_wr_n && (s_addr != ADDR_CW);
  assign data_oe   = rd_active;

  always_comb begin
    data_out = 8'h00;
    if (rd_active) begin
      if (stat_latched[s_addr]) data_out = status_in[{s_addr, 3'b000} +: 8];
      else                      data_out = ol_in[{s_addr, rd_ptr[s_addr], 3'b000} +: 8];
    end
  end

endmodule
